// File: rtl/mem_arbiter.sv
// Arbiter sharing one external memory port between instruction fetch and MEM-stage data.
// Data has priority; a starvation counter forces a fetch grant, and a timeout aborts hung transactions.
module mem_arbiter #(
  parameter int unsigned FETCH_STARVE = 4,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned TIMEOUT_W    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        owner_d
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int unsigned STARVE_W = (FETCH_STARVE < 1) ? 1 : $clog2(FETCH_STARVE + 1);
  localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(FETCH_STARVE);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST   = TIMEOUT_W'(TIMEOUT - 1);

  logic [1:0]           state_q,    state_d;
  logic [STARVE_W-1:0]  starve_q,   starve_d;
  logic [TIMEOUT_W-1:0] tmo_q,      tmo_d;
  logic                 m_req_q,    m_req_d;
  logic                 m_we_q,     m_we_d;
  logic [31:0]          m_addr_q,   m_addr_d;
  logic [31:0]          m_wdata_q,  m_wdata_d;
  logic [3:0]           m_wstrb_q,  m_wstrb_d;
  logic                 owner_q,    owner_d_d;
  logic                 if_ack_q,   if_ack_d;
  logic                 if_err_q,   if_err_d;
  logic [31:0]          if_rdata_q, if_rdata_d;
  logic                 d_ack_q,    d_ack_d;
  logic                 d_err_q,    d_err_d;
  logic [31:0]          d_rdata_q,  d_rdata_d;

  logic grant_data;
  logic grant_fetch;

  // A saturated starve count hands a tie to fetch.
  assign grant_data  = d_req && !(if_req && (starve_q == STARVE_MAX));
  assign grant_fetch = if_req && !grant_data;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wstrb_d  = m_wstrb_q;
    owner_d_d  = owner_q;
    if_ack_d   = if_ack_q;
    if_err_d   = if_err_q;
    if_rdata_d = if_rdata_q;
    d_ack_d    = d_ack_q;
    d_err_d    = d_err_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d   = BUSY;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_wstrb_d = d_wstrb;
          owner_d_d = 1'b1;
          tmo_d     = '0;
        end else if (grant_fetch) begin
          state_d   = BUSY;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          m_wstrb_d = '1;
          owner_d_d = 1'b0;
          tmo_d     = '0;
        end

        if (!if_req || grant_fetch) begin
          starve_d = '0;
        end else if (grant_data && (starve_q != STARVE_MAX)) begin
          starve_d = starve_q + STARVE_W'(1);
        end
      end

      BUSY: begin
        tmo_d = tmo_q + TIMEOUT_W'(1);
        // m_ack takes precedence over a timeout expiring in the same cycle.
        if (m_ack) begin
          state_d = RESP;
          m_req_d = 1'b0;
          if (owner_q) begin
            d_ack_d = 1'b1;
            d_err_d = 1'b0;
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_err_d   = 1'b0;
            if_rdata_d = m_rdata;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = RESP;
          m_req_d = 1'b0;
          if (owner_q) begin
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end else begin
            if_ack_d = 1'b1;
            if_err_d = 1'b1;
          end
        end
      end

      RESP: begin
        state_d  = IDLE;
        if_ack_d = 1'b0;
        if_err_d = 1'b0;
        d_ack_d  = 1'b0;
        d_err_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      tmo_q      <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wstrb_q  <= '0;
      owner_q    <= 1'b0;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      if_rdata_q <= '0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_wstrb_q  <= m_wstrb_d;
      owner_q    <= owner_d_d;
      if_ack_q   <= if_ack_d;
      if_err_q   <= if_err_d;
      if_rdata_q <= if_rdata_d;
      d_ack_q    <= d_ack_d;
      d_err_q    <= d_err_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_ack   = if_ack_q;
  assign if_err   = if_err_q;
  assign if_rdata = if_rdata_q;
  assign d_ack    = d_ack_q;
  assign d_err    = d_err_q;
  assign d_rdata  = d_rdata_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wstrb  = m_wstrb_q;
  assign owner_d  = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, starvation, store, timeout and async reset.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_err;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        owner_d;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_drdata;
  int unsigned cnt;

  mem_arbiter #(
    .FETCH_STARVE(4),
    .TIMEOUT     (8),
    .TIMEOUT_W   (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_ack  (if_ack),
    .if_err  (if_err),
    .if_rdata(if_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_wstrb (d_wstrb),
    .d_ack   (d_ack),
    .d_err   (d_err),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ack   (m_ack),
    .m_rdata (m_rdata),
    .owner_d (owner_d)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0; m_ack = 0; m_rdata = '0;
    step(); step();
    chk("rst_m_req", {31'd0, m_req}, 0);
    chk("rst_acks", {28'd0, if_ack, d_ack, if_err, d_err}, 0);
    chk("rst_owner", {31'd0, owner_d}, 0);
    chk("rst_m_addr", m_addr, 0);
    reset = 1'b1;
    step();

    // 1: single fetch
    if_req = 1; if_addr = 32'h100;
    step();
    chk("t1_m_req", {31'd0, m_req}, 1);
    chk("t1_m_addr", m_addr, 32'h100);
    chk("t1_m_wstrb", {28'd0, m_wstrb}, 32'hF);
    chk("t1_m_we", {31'd0, m_we}, 0);
    m_ack = 1; m_rdata = 32'h13;
    step();
    chk("t1_if_ack", {31'd0, if_ack}, 1);
    chk("t1_if_rdata", if_rdata, 32'h13);
    chk("t1_if_err", {31'd0, if_err}, 0);
    chk("t1_m_req_resp", {31'd0, m_req}, 0);
    if_req = 0; m_ack = 0;
    step();
    chk("t1_if_ack_off", {31'd0, if_ack}, 0);

    // 2: simultaneous requests, data first
    if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000;
    step();
    chk("t2_owner_d", {31'd0, owner_d}, 1);
    chk("t2_m_addr", m_addr, 32'h2000);
    m_ack = 1; m_rdata = 32'hCAFE0001;
    step();
    chk("t2_d_ack", {31'd0, d_ack}, 1);
    chk("t2_if_ack_low", {31'd0, if_ack}, 0);
    chk("t2_d_rdata", d_rdata, 32'hCAFE0001);
    d_req = 0; m_ack = 0;
    step();
    step();
    chk("t2_owner_f", {31'd0, owner_d}, 0);
    chk("t2_m_addr_f", m_addr, 32'h104);
    m_ack = 1; m_rdata = 32'h33;
    step();
    chk("t2_if_ack", {31'd0, if_ack}, 1);
    chk("t2_d_ack_low", {31'd0, d_ack}, 0);
    chk("t2_if_rdata", if_rdata, 32'h33);
    if_req = 0; m_ack = 0;
    step();

    // 3: starvation, four data grants then fetch, then counter cleared
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h2100;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("t3_owner_%0d", k), {31'd0, owner_d}, (k == 4) ? 32'd0 : 32'd1);
      chk($sformatf("t3_m_req_%0d", k), {31'd0, m_req}, 1);
      m_ack = 1; m_rdata = 32'h1000 + k;
      step();
      chk($sformatf("t3_acks_%0d", k), {30'd0, if_ack, d_ack}, (k == 4) ? 32'd2 : 32'd1);
      m_ack = 0;
      if (k == 5) begin
        if_req = 0; d_req = 0;
      end
      step();
    end
    chk("t3_d_rdata", d_rdata, 32'h1005);
    chk("t3_if_rdata", if_rdata, 32'h1004);
    exp_drdata = 32'h1005;

    // 4: store with m_ack in the third BUSY cycle
    d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
    step();
    chk("t4_m_we", {31'd0, m_we}, 1);
    chk("t4_m_wstrb", {28'd0, m_wstrb}, 32'h3);
    chk("t4_m_wdata_c1", m_wdata, 32'hDEADBEEF);
    d_wdata = 32'h0; d_addr = 32'h0;
    step();
    chk("t4_m_wdata_c2", m_wdata, 32'hDEADBEEF);
    chk("t4_m_addr_c2", m_addr, 32'h3000);
    step();
    chk("t4_m_wdata_c3", m_wdata, 32'hDEADBEEF);
    m_ack = 1; m_rdata = 32'h00000BAD;
    step();
    chk("t4_d_ack", {31'd0, d_ack}, 1);
    chk("t4_d_rdata", d_rdata, exp_drdata);
    d_req = 0; d_we = 0; m_ack = 0;
    step();
    chk("t4_d_ack_off", {31'd0, d_ack}, 0);

    // 5a: timeout with no m_ack
    d_req = 1; d_addr = 32'h4000; m_rdata = 32'hFFFFFFFF;
    step();
    cnt = 0;
    while (m_req === 1'b1 && cnt < 20) begin
      cnt++;
      step();
    end
    chk("t5_mreq_cycles", cnt, 8);
    chk("t5_d_ack", {31'd0, d_ack}, 1);
    chk("t5_d_err", {31'd0, d_err}, 1);
    chk("t5_d_rdata", d_rdata, exp_drdata);
    d_req = 0;
    step();
    chk("t5_d_err_off", {31'd0, d_err}, 0);
    // 5b: normal request after timeout
    d_req = 1; d_addr = 32'h4004;
    step();
    m_ack = 1; m_rdata = 32'h4444;
    step();
    chk("t5b_d_ack", {31'd0, d_ack}, 1);
    chk("t5b_d_err", {31'd0, d_err}, 0);
    chk("t5b_d_rdata", d_rdata, 32'h4444);
    d_req = 0; m_ack = 0;
    step();
    // 5c: m_ack in the eighth cycle beats the timeout
    d_req = 1; d_addr = 32'h4008;
    step();
    repeat (7) step();
    chk("t5c_m_req_c8", {31'd0, m_req}, 1);
    m_ack = 1; m_rdata = 32'h8888;
    step();
    chk("t5c_d_ack", {31'd0, d_ack}, 1);
    chk("t5c_d_err", {31'd0, d_err}, 0);
    chk("t5c_d_rdata", d_rdata, 32'h8888);
    d_req = 0; m_ack = 0;
    step();

    // 6: async reset mid-BUSY
    d_req = 1; d_addr = 32'h5000;
    step();
    chk("t6_busy_m_req", {31'd0, m_req}, 1);
    chk("t6_busy_owner", {31'd0, owner_d}, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_m_req", {31'd0, m_req}, 0);
    chk("t6_rst_owner", {31'd0, owner_d}, 0);
    chk("t6_rst_acks", {30'd0, if_ack, d_ack}, 0);
    d_req = 0;
    m_ack = 1;
    step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6_quiet_%0d", k), {29'd0, m_req, if_ack, d_ack}, 0);
    end
    m_ack = 0;
    if_req = 1; if_addr = 32'h600;
    step();
    chk("t6_new_m_addr", m_addr, 32'h600);
    m_ack = 1; m_rdata = 32'h77;
    step();
    chk("t6_new_if_ack", {31'd0, if_ack}, 1);
    chk("t6_new_if_rdata", if_rdata, 32'h77);
    if_req = 0; m_ack = 0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
